// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM encoding, shadow-config reset values,
// watchdog default and grant-index width helper. No logic, no latency, no flow control.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    localparam logic       CFG_RST_PARITY_EN = 1'b0;
    localparam logic       CFG_RST_PARITY_OE = 1'b0;
    localparam logic       CFG_RST_BIT78     = 1'b1;
    localparam logic [3:0] CFG_RST_BAUD      = 4'd0;

    localparam int TIMEOUT_CYC_DEF = 65535;

    // Index width for NREQ requesters; never below one bit.
    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from i_ptr+1 with wrap.
// Zero latency; no backpressure, o_valid simply reports that any request is set.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = gid_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [GW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [GW-1:0]   o_idx,
    output logic            o_valid
);

    int w_best_dist;
    int w_dist;

    // Each requester's distance from the slot after the pointer; the smallest set one wins.
    always_comb begin
        w_best_dist = NREQ;
        w_dist      = 0;
        o_idx       = '0;
        o_valid     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - int'(i_ptr) - 1) % NREQ;
            if (i_req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_idx       = GW'(i);
                o_valid     = 1'b1;
            end
        end
    end

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_onehot[i] = o_valid && (o_idx == GW'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter: grant -> ack (+1) -> tx_start (+2), then waits for tx_busy to rise and fall.
// Grants only in IDLE with tx_busy low; optional watchdog under UART_TX_ARB_TIMEOUT_EN returns to IDLE with a tx_err pulse.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int GW          = gid_w(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_oe,
    input  logic              cfg_bit78,
    input  logic [3:0]        cfg_baud_val,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              tx_parity_en,
    output logic              tx_parity_oe,
    output logic              tx_bit78,
    output logic [3:0]        tx_baud_val,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic              tx_err
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_grant;

    logic [GW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_ack;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;
    logic [GW-1:0]     r_grant_id;
    logic              r_busy;
    logic              r_parity_en;
    logic              r_parity_oe;
    logic              r_bit78;
    logic [3:0]        r_baud_val;

    logic [NREQ-1:0]   w_pick_oh;
    logic [GW-1:0]     w_pick_idx;
    logic              w_pick_vld;
    logic [7:0]        w_byte;

    uart_rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_vld)
    );

    always_comb begin
        w_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_oh[i]) begin
                w_byte = w_byte | req_data[i*8 +: 8];
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_wd_cnt;
    logic        r_tx_err;
    logic        w_wd_fire;

    // Counter is zero in the first WAIT_BUSY cycle, so the pulse lands TIMEOUT_CYC edges after entry.
    assign w_wd_fire = ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)) && (r_wd_cnt == WD_LIM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wd_cnt <= '0;
            r_tx_err <= 1'b0;
        end else begin
            r_tx_err <= w_wd_fire;
            if (r_state == ST_LAUNCH) begin
                r_wd_cnt <= '0;
            end else if ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
        end
    end

    assign tx_err = r_tx_err;
`else
    assign tx_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld && !tx_busy) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH:    w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy)  w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (w_wd_fire) begin
            w_state_nxt = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr       <= GW'(NREQ - 1);
            r_ack       <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_grant_id  <= '0;
            r_busy      <= 1'b0;
            r_parity_en <= CFG_RST_PARITY_EN;
            r_parity_oe <= CFG_RST_PARITY_OE;
            r_bit78     <= CFG_RST_BIT78;
            r_baud_val  <= CFG_RST_BAUD;
        end else begin
            r_ack      <= w_grant ? w_pick_oh : '0;
            r_tx_start <= (r_state == ST_LAUNCH);
            r_busy     <= (w_state_nxt != ST_IDLE);
            // Shadow config follows the inputs only between frames.
            if (r_state == ST_IDLE) begin
                r_parity_en <= cfg_parity_en;
                r_parity_oe <= cfg_parity_oe;
                r_bit78     <= cfg_bit78;
                r_baud_val  <= cfg_baud_val;
            end
            // A 7-bit frame uses the config loaded in this same cycle, so bit 7 follows cfg_bit78.
            if (w_grant) begin
                r_tx_data  <= {w_byte[7] & cfg_bit78, w_byte[6:0]};
                r_grant_id <= w_pick_idx;
                r_ptr      <= w_pick_idx;
            end
        end
    end

    assign ack          = r_ack;
    assign tx_start     = r_tx_start;
    assign tx_data      = r_tx_data;
    assign grant_id     = r_grant_id;
    assign busy         = r_busy;
    assign tx_parity_en = r_parity_en;
    assign tx_parity_oe = r_parity_oe;
    assign tx_bit78     = r_bit78;
    assign tx_baud_val  = r_baud_val;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among NREQ byte requesters.
- Sequences the transmitter: selects a winner, captures its byte, pulses the start strobe, then waits for the transmitter's busy signal to rise and fall before granting again.
- Holds shadow copies of the frame configuration (parity enable, parity odd/even, 7/8-bit, baud select) and updates them only between frames, so a configuration change never corrupts a frame in flight.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 65535, watchdog limit in clk cycles; used only with UART_TX_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- req  in  NREQ  per-requester request; requester holds it with stable data until ack.
- req_data  in  8*NREQ  flattened bytes; requester i uses bits [8i+7:8i].
- ack  out  NREQ  one-hot, single-cycle; byte i has been captured.
- cfg_parity_en  in  1  parity enable.
- cfg_parity_oe  in  1  1 = odd, 0 = even.
- cfg_bit78  in  1  1 = 8 data bits, 0 = 7 data bits.
- cfg_baud_val  in  4  baud select code.
- tx_busy  in  1  transmitter busy (frame in progress).
- tx_start  out  1  single-cycle frame start strobe.
- tx_data  out  8  byte to transmit.
- tx_parity_en, tx_parity_oe, tx_bit78  out  1 each  shadow configuration.
- tx_baud_val  out  4  shadow baud code.
- grant_id  out  clog2(NREQ)  index of the last granted requester.
- busy  out  1  high whenever state is not IDLE.
- tx_err  out  1  single-cycle watchdog pulse; constant 0 without the macro.

Behaviour:
- Reset values (applied at the clk edge with reset=0):
  - state IDLE; ack 0; tx_start 0; tx_data 0; grant_id 0; busy 0; tx_err 0.
  - Round-robin pointer NREQ-1, so requester 0 has first priority.
  - Shadow configuration: parity_en 0, parity_oe 0, bit78 1, baud_val 0.
- All outputs are registered.
- IDLE:
  - Shadow configuration reloads from cfg_* on every cycle.
  - If (|req) and tx_busy=0 in cycle N:
    - The winner is the first set req bit searching upward from pointer+1, with wrap-around.
    - At the end of cycle N: tx_data <= winner byte; grant_id <= winner; pointer <= winner; ack[winner] <= 1; state <= LAUNCH.
  - If tx_busy=1, no grant is made, regardless of req.
- Capture rule: when tx_bit78=0, tx_data[7] is forced to 0 at capture, using the configuration value loaded in that same cycle (cfg_bit78).
- LAUNCH (cycle N+1): ack high for this cycle only; tx_start <= 1; state <= WAIT_BUSY.
- WAIT_BUSY (tx_start high in cycle N+2 only): stay until tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until tx_busy=0, then go to IDLE. A new grant is possible in the first IDLE cycle.
- Shadow configuration and tx_data are frozen in LAUNCH, WAIT_BUSY and WAIT_DONE.
- If a requester deasserts req before its ack arrives, the captured byte is still sent.
- A req bit that is still high in the cycle after its ack counts as a new request.
- Reset mid-operation: state returns to IDLE and tx_start is low from the next edge. The arbiter does not abort a transmitter frame already in flight; the transmitter has its own reset.
- Bytes are sent in grant order; there is no buffering beyond the single captured byte.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_BUSY and counts in WAIT_BUSY and WAIT_DONE.
  - When the count reaches TIMEOUT_CYC: tx_err pulses for one cycle and state returns to IDLE. The pointer is kept.
- Undefined: no counter is built, tx_err is tied to 0, and the block can wait in WAIT_BUSY/WAIT_DONE indefinitely.

Decomposition:
- Package uart_pkg:
  - FSM state encodings (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, 2 bits).
  - Shadow configuration reset constants.
  - TIMEOUT_CYC default.
  - Width function for grant_id.
- Sub-module uart_rr_pick: combinational round-robin picker.
  - Inputs: req, pointer.
  - Outputs: one-hot winner, index, valid.

Test Plan (NREQ=4):
1. Reset: reset=0 for 3 cycles with req=4'b1111 and tx_busy=0 → ack=0, tx_start=0, busy=0, tx_bit78=1, tx_baud_val=0.
2. Single grant: req=4'b0100, byte 2=8'hA5, cfg_baud_val=12 in cycle N →
   - ack=4'b0100 in N+1; tx_start in N+2; tx_data=8'hA5; grant_id=2; tx_baud_val=12.
   - tx_busy high 3 cycles later for 10 cycles → busy stays 1 until one cycle after tx_busy falls.
3. Round robin: req=4'b1111 held, transmitter model busy for 8 cycles per frame → grant_id sequence 0,1,2,3,0.
4. Width and configuration:
   - cfg_bit78=0, byte 8'hFF → tx_data=8'h7F.
   - Toggle cfg_parity_oe during WAIT_DONE → tx_parity_oe changes only in the next IDLE cycle.
5. Blocked: tx_busy=1 in IDLE with req=4'b0001 for 5 cycles → no ack. Release tx_busy → ack 1 cycle later.
6. Watchdog: with the macro and TIMEOUT_CYC=16, tx_busy never rises → tx_err pulses 16 cycles after entry to WAIT_BUSY, then IDLE. Without the macro → the block stays in WAIT_BUSY. Assert reset=0 there → IDLE next edge.
